// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP stream engine.
// Neighbour bit positions follow raster order around the centre pixel.
package lbp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BORDER,
    FILL,
    STEP,
    EVAL,
    DONE
  } state_t;

  localparam int NB_TL = 0;
  localparam int NB_T  = 1;
  localparam int NB_TR = 2;
  localparam int NB_L  = 3;
  localparam int NB_R  = 4;
  localparam int NB_BL = 5;
  localparam int NB_B  = 6;
  localparam int NB_BR = 7;

  localparam int FILL_READS = 9;
  localparam int STEP_READS = 3;

endpackage

// File: rtl/lbp_window_3x3.sv
// 3x3 pixel window with load-at-position and shift-left controls,
// producing the thresholded LBP code of the centre pixel.
module lbp_window_3x3
  import lbp_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [1:0]        load_row,
  input  logic [1:0]        load_col,
  input  logic [DATA_W-1:0] load_data,
  input  logic [DATA_W-1:0] thresh,
  output logic [7:0]        code
);

  logic [DATA_W-1:0] win [3][3];
  logic [DATA_W:0]   ref_v;

  // Shift only touches columns 0..1, so a same-cycle load of column 2 never collides.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      if (shift) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            win[r][c] <= win[r][c+1];
      end
      if (load)
        win[load_row][load_col] <= load_data;
    end
  end

  assign ref_v = {1'b0, win[1][1]} + {1'b0, thresh};

  function automatic logic ge(
    input logic [DATA_W-1:0] v,
    input logic [DATA_W:0]   r
  );
    return {1'b0, v} >= r;
  endfunction

  always_comb begin
    code = '0;
    code[NB_TL] = ge(win[0][0], ref_v);
    code[NB_T]  = ge(win[0][1], ref_v);
    code[NB_TR] = ge(win[0][2], ref_v);
    code[NB_L]  = ge(win[1][0], ref_v);
    code[NB_R]  = ge(win[1][2], ref_v);
    code[NB_BL] = ge(win[2][0], ref_v);
    code[NB_B]  = ge(win[2][1], ref_v);
    code[NB_BR] = ge(win[2][2], ref_v);
  end

endmodule

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine over a W x W image with a sliding window.
// Define LBP_BORDER_ZERO_EN to zero-fill border codes before the interior.
module lbp_stream_engine
  import lbp_pkg::*;
#(
  parameter int IMG_W_LOG2 = 7,
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 2*IMG_W_LOG2
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic [ADDR_W-1:0] gray_addr,
  output logic              gray_req,
  input  logic [DATA_W-1:0] gray_data,
  input  logic [DATA_W-1:0] thresh,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              lbp_valid,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam logic [IMG_W_LOG2-1:0] ONE  = IMG_W_LOG2'(1);
  localparam logic [IMG_W_LOG2-1:0] MAXC = '1;
  localparam logic [IMG_W_LOG2-1:0] LAST = MAXC - ONE;

  state_t                state;
  logic [IMG_W_LOG2-1:0] i;
  logic [IMG_W_LOG2-1:0] j;
  logic [3:0]            rd_cnt;
  logic [1:0]            rd_r;
  logic [1:0]            rd_c;
  logic [3:0]            last_rd;
  logic [IMG_W_LOG2-1:0] rd_row;
  logic [IMG_W_LOG2-1:0] rd_col;
  logic                  rd_go;
  logic                  win_shift;
  logic [7:0]            code;

  assign gray_req  = (state == FILL) || (state == STEP);
  assign rd_go     = gray_req && gray_ready;
  assign win_shift = (state == STEP) && (rd_cnt == '0) && gray_ready;
  assign last_rd   = (state == STEP) ? 4'(STEP_READS-1)
                                     : 4'(FILL_READS-1);

  // Column offset is 0..2 around j; STEP pins it to 2 (the new column).
  assign rd_row    = i + IMG_W_LOG2'(rd_r) - ONE;
  assign rd_col    = j + IMG_W_LOG2'(rd_c) - ONE;
  assign gray_addr = gray_req ? {rd_row, rd_col} : '0;

  lbp_window_3x3 #(
    .DATA_W (DATA_W)
  ) u_win (
    .clk       (clk),
    .reset     (reset),
    .load      (rd_go),
    .shift     (win_shift),
    .load_row  (rd_r),
    .load_col  (rd_c),
    .load_data (gray_data),
    .thresh    (thresh),
    .code      (code)
  );

`ifdef LBP_BORDER_ZERO_EN
  logic [ADDR_W-1:0]     b_addr;
  logic [ADDR_W-1:0]     b_next;
  logic [IMG_W_LOG2-1:0] b_r;
  logic [IMG_W_LOG2-1:0] b_c;
  logic                  b_edge;

  assign {b_r, b_c} = b_addr;
  assign b_edge     = (b_r == '0) || (b_r == MAXC);

  // Edge rows walk every column; middle rows hop from col 0 to col W-1.
  always_comb begin
    b_next = b_addr;
    unique case (1'b1)
      b_edge:                  b_next = b_addr + ADDR_W'(1);
      !b_edge && (b_c == '0):  b_next = {b_r, MAXC};
      !b_edge && (b_c != '0):  b_next = {b_r + ONE, {IMG_W_LOG2{1'b0}}};
      default:                 b_next = b_addr;
    endcase
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      i         <= ONE;
      j         <= ONE;
      rd_cnt    <= '0;
      rd_r      <= '0;
      rd_c      <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
`ifdef LBP_BORDER_ZERO_EN
      b_addr    <= '0;
`endif
    end else begin
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gray_ready) begin
            i      <= ONE;
            j      <= ONE;
            rd_cnt <= '0;
            rd_r   <= '0;
            rd_c   <= '0;
`ifdef LBP_BORDER_ZERO_EN
            b_addr <= '0;
            state  <= BORDER;
`else
            state  <= FILL;
`endif
          end
        end
`ifdef LBP_BORDER_ZERO_EN
        BORDER: begin
          lbp_valid <= 1'b1;
          lbp_addr  <= b_addr;
          lbp_data  <= '0;
          b_addr    <= b_next;
          if (b_addr == {MAXC, MAXC})
            state <= FILL;
        end
`endif
        FILL, STEP: begin
          if (gray_ready) begin
            if (rd_cnt == last_rd) begin
              rd_cnt <= '0;
              rd_r   <= '0;
              state  <= EVAL;
            end else begin
              rd_cnt <= rd_cnt + 4'd1;
              if (rd_r == 2'd2) begin
                rd_r <= '0;
                rd_c <= rd_c + 2'd1;
              end else begin
                rd_r <= rd_r + 2'd1;
              end
            end
          end
        end
        EVAL: begin
          lbp_valid <= 1'b1;
          lbp_addr  <= {i, j};
          lbp_data  <= code;
          if (i == LAST && j == LAST) begin
            state <= DONE;
          end else if (j == LAST) begin
            j     <= ONE;
            i     <= i + ONE;
            rd_c  <= 2'd0;
            state <= FILL;
          end else begin
            j     <= j + ONE;
            rd_c  <= 2'd2;
            state <= STEP;
          end
        end
        DONE: begin
          finish <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Randomised bench for lbp_stream_engine against a frame-level model.
// Honours LBP_BORDER_ZERO_EN the same way as the design.
module tb_lbp_stream_engine;

  localparam int LG = 3;
  localparam int W  = 1 << LG;
  localparam int N  = W * W;
  localparam int DW = 8;
  localparam int AW = 2 * LG;
`ifdef LBP_BORDER_ZERO_EN
  localparam int OFF = 4*W - 4;
`else
  localparam int OFF = 0;
`endif
  localparam int ROW_CYC = 10 + 4*(W-3);
  localparam int BASE    = (W-2)*ROW_CYC + 2 + OFF;
  localparam int ABORT_C = OFF + ROW_CYC + 10 + 4*2;
  localparam int STALL_C = OFF + ROW_CYC + 10 + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          gray_ready;
  logic [AW-1:0] gray_addr;
  logic          gray_req;
  logic [DW-1:0] gray_data;
  logic [DW-1:0] thresh;
  logic [AW-1:0] lbp_addr;
  logic          lbp_valid;
  logic [7:0]    lbp_data;
  logic          finish;

  logic [DW-1:0] img [N];

  int exp_wa[$];
  int exp_wd[$];
  int exp_ra[$];
  int n_pass;
  int n_chk;

  always #5 clk = ~clk;

  assign gray_data = img[gray_addr];

  lbp_stream_engine #(
    .IMG_W_LOG2 (LG),
    .DATA_W     (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_addr  (gray_addr),
    .gray_req   (gray_req),
    .gray_data  (gray_data),
    .thresh     (thresh),
    .lbp_addr   (lbp_addr),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Neighbours in raster order around the centre give bits 0..7.
  function automatic int ref_code(input int r, input int c, input int th);
    int code;
    int k;
    int ctr;
    code = 0;
    k = 0;
    ctr = int'(img[r*W + c]);
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) begin
          if (int'(img[(r+dr)*W + c + dc]) >= ctr + th)
            code |= (1 << k);
          k++;
        end
    return code;
  endfunction

  task automatic build_model(input int th);
    exp_wa.delete();
    exp_wd.delete();
    exp_ra.delete();
`ifdef LBP_BORDER_ZERO_EN
    for (int a = 0; a < N; a++)
      if (a / W == 0 || a / W == W-1 || a % W == 0 || a % W == W-1) begin
        exp_wa.push_back(a);
        exp_wd.push_back(0);
      end
`endif
    for (int r = 1; r <= W-2; r++) begin
      for (int dc = -1; dc <= 1; dc++)
        for (int dr = -1; dr <= 1; dr++)
          exp_ra.push_back((r+dr)*W + 1 + dc);
      for (int c = 2; c <= W-2; c++)
        for (int dr = -1; dr <= 1; dr++)
          exp_ra.push_back((r+dr)*W + c + 1);
      for (int c = 1; c <= W-2; c++) begin
        exp_wa.push_back(r*W + c);
        exp_wd.push_back(ref_code(r, c, th));
      end
    end
  endtask

  task automatic check_zero_out(input string tag);
    check({tag, "_valid"}, lbp_valid, 0);
    check({tag, "_laddr"}, lbp_addr, 0);
    check({tag, "_ldata"}, lbp_data, 0);
    check({tag, "_finish"}, finish, 0);
    check({tag, "_req"}, gray_req, 0);
    check({tag, "_gaddr"}, gray_addr, 0);
  endtask

  task automatic run_frame(input int stall_at, input int stall_pct,
                           input int abort_at);
    int  cyc;
    int  stalls;
    int  held;
    bit  prev_stall;
    bit  done;
    cyc = 0;
    stalls = 0;
    held = 0;
    prev_stall = 0;
    done = 0;
    gray_ready = 1'b1;
    while (!done) begin
      @(posedge clk);
      #1;
      cyc++;
      if (lbp_valid) begin
        if (exp_wa.size() == 0) begin
          check("extra_write", lbp_addr, -1);
        end else begin
          check("wr_addr", lbp_addr, exp_wa.pop_front());
          check("wr_data", lbp_data, exp_wd.pop_front());
        end
      end
      if (!gray_req) check("gaddr_idle", gray_addr, 0);
      if (prev_stall) begin
        check("stall_req", gray_req, 1);
        check("stall_addr", gray_addr, held);
      end
      prev_stall = 0;
      if (finish) begin
        check("frame_cycles", cyc, BASE + stalls);
        check("writes_left", exp_wa.size(), 0);
        check("reads_left", exp_ra.size(), 0);
        gray_ready = 1'b0;
        done = 1;
      end else if (abort_at > 0 && cyc == abort_at) begin
        check("abort_in_eval", gray_req, 0);
        #2 reset = 1'b1;
        #1 check_zero_out("abort_now");
        @(posedge clk);
        #1;
        check("abort_next_valid", lbp_valid, 0);
        check("abort_next_addr", lbp_addr, 0);
        check("abort_next_data", lbp_data, 0);
        check("abort_writes_left", exp_wa.size(), (W-2)*(W-2) - 8);
        gray_ready = 1'b0;
        reset = 1'b0;
        done = 1;
      end else if (cyc > 4000) begin
        check("timeout", cyc, BASE + stalls);
        gray_ready = 1'b0;
        done = 1;
      end else begin
        gray_ready = 1'b1;
        if (gray_req) begin
          if (stall_at > 0 && cyc >= stall_at && cyc < stall_at + 3)
            gray_ready = 1'b0;
          if ($urandom_range(0, 99) < stall_pct)
            gray_ready = 1'b0;
        end
        if (gray_req && !gray_ready) begin
          prev_stall = 1;
          stalls++;
          held = int'(gray_addr);
        end else if (gray_req) begin
          if (exp_ra.size() == 0) check("extra_read", gray_addr, -1);
          else check("rd_addr", gray_addr, exp_ra.pop_front());
        end
      end
    end
    if (abort_at == 0) begin
      @(posedge clk);
      #1;
      check("finish_one_cycle", finish, 0);
      check("idle_after", gray_req, 0);
    end
  endtask

  task automatic fill_rand(input int maxv);
    for (int a = 0; a < N; a++)
      img[a] = DW'($urandom_range(0, maxv));
  endtask

  initial begin
    n_pass = 0;
    n_chk = 0;
    reset = 1'b1;
    gray_ready = 1'b0;
    thresh = '0;
    for (int a = 0; a < N; a++) img[a] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_out("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("idle_wait", gray_req, 0);

    for (int a = 0; a < N; a++) img[a] = 8'd50;
    thresh = 8'd0;
    build_model(0);
    run_frame(0, 0, 0);

    thresh = 8'd1;
    build_model(1);
    run_frame(0, 0, 0);

    for (int a = 0; a < N; a++) img[a] = DW'(a % W);
    thresh = 8'd0;
    build_model(0);
    run_frame(0, 0, 0);

    fill_rand(255);
    thresh = DW'($urandom_range(0, 40));
    build_model(int'(thresh));
    run_frame(STALL_C, 0, 0);

    fill_rand(255);
    thresh = DW'($urandom_range(200, 255));
    build_model(int'(thresh));
    run_frame(0, 20, 0);

    fill_rand(255);
    thresh = 8'd0;
    build_model(0);
    run_frame(0, 0, ABORT_C);
    @(posedge clk);
    #1;
    build_model(0);
    run_frame(0, 0, 0);

    fill_rand(3);
    thresh = DW'($urandom_range(0, 2));
    build_model(int'(thresh));
    run_frame(0, 10, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
